// File: rtl/serial_word_tx.sv
// serial_word_tx: start/MSB-first data/stop word transmitter with load/ready handshake.
// Define SERIAL_WORD_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_word_tx #(
   parameter int DATA_W = 10,
   parameter int DIV    = 25
) (
   input  logic              CLOCK_50,
   input  logic              Resetn,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              ser_out,
   output logic              busy,
   output logic              done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_TOP  = IW'(DATA_W - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef SERIAL_WORD_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif

   logic [2:0]        state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [IW-1:0]     idx, idx_n;
   logic [DATA_W-1:0] sh, sh_n;
   logic              wrap;
   logic              ser_n, done_n;
`ifdef SERIAL_WORD_TX_PARITY_EN
   logic              par, par_n;
`endif

   assign wrap = (cnt == CNT_LAST);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_n   = par;
`endif
      case (state)
         IDLE: begin
            if (load) begin
               sh_n    = data_in;
`ifdef SERIAL_WORD_TX_PARITY_EN
               par_n   = ^data_in;
`endif
               cnt_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (wrap) begin
               cnt_n   = '0;
               idx_n   = IDX_TOP;
               state_n = DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (wrap) begin
               cnt_n = '0;
               sh_n  = sh << 1;
               if (idx == '0) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  idx_n = idx - 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`ifdef SERIAL_WORD_TX_PARITY_EN
         PARITY: begin
            if (wrap) begin
               cnt_n   = '0;
               state_n = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            if (wrap) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   // Outputs are flops fed from next-state values so they line up with state.
   always_comb begin
      ser_n = 1'b1;
      case (state_n)
         START:   ser_n = 1'b0;
         DATA:    ser_n = sh_n[DATA_W-1];
`ifdef SERIAL_WORD_TX_PARITY_EN
         PARITY:  ser_n = par_n;
`endif
         default: ser_n = 1'b1;
      endcase
      done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         sh      <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
         par     <= 1'b0;
`endif
         ready   <= 1'b1;
         busy    <= 1'b0;
         ser_out <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         sh      <= sh_n;
`ifdef SERIAL_WORD_TX_PARITY_EN
         par     <= par_n;
`endif
         ready   <= (state_n == IDLE);
         busy    <= (state_n != IDLE);
         ser_out <= ser_n;
         done    <= done_n;
      end
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed frame checks for serial_word_tx at DIV=4 and DIV=1.
// Expected line levels are built from the word, the bit period and the frame layout.
module tb_serial_word_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] data4 = '0, data1 = '0;
   logic       load4 = 1'b0, load1 = 1'b0;
   logic       ready4, ser4, busy4, done4;
   logic       ready1, ser1, busy1, done1;

   int n_run = 0;
   int n_fail = 0;

   localparam logic [9:0] WA = 10'b1010101010;
   localparam logic [9:0] WB = 10'b1101010101;

`ifdef SERIAL_WORD_TX_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif

   always #5 clk = ~clk;

   serial_word_tx #(.DATA_W(10), .DIV(4)) dut (
      .CLOCK_50(clk), .Resetn(rst_n), .data_in(data4), .load(load4),
      .ready(ready4), .ser_out(ser4), .busy(busy4), .done(done4)
   );

   serial_word_tx #(.DATA_W(10), .DIV(1)) dut1 (
      .CLOCK_50(clk), .Resetn(rst_n), .data_in(data1), .load(load1),
      .ready(ready1), .ser_out(ser1), .busy(busy1), .done(done1)
   );

   task automatic check(input string tag, input int cyc,
                        input logic got, input logic exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d got %b expected %b", tag, cyc, got, exp);
      end
   endtask

   task automatic check_idle(input int sel, input int cyc);
      check("idle_ser",   cyc, sel ? ser1   : ser4,   1'b1);
      check("idle_ready", cyc, sel ? ready1 : ready4, 1'b1);
      check("idle_busy",  cyc, sel ? busy1  : busy4,  1'b0);
      check("idle_done",  cyc, sel ? done1  : done4,  1'b0);
   endtask

   // Leaves time just after acceptance edge k.
   task automatic start(input int sel, input logic [9:0] w, input bit hold);
      @(posedge clk);
      #1;
      if (sel != 0) begin load1 = 1'b1; data1 = w; end
      else begin load4 = 1'b1; data4 = w; end
      @(posedge clk);
      #1;
      if (!hold) begin load1 = 1'b0; load4 = 1'b0; end
   endtask

   // Checks cycles k+1..k+F, then idle cycle k+F+1; rej>0 pulses load at k+rej.
   task automatic run_frame(input int sel, input logic [9:0] w, input int rej);
      int div;
      int f;
      logic bitv[NB];
      div = (sel != 0) ? 1 : 4;
      f = NB * div;
      bitv[0] = 1'b0;
      for (int i = 0; i < 10; i++) bitv[1+i] = w[9-i];
`ifdef SERIAL_WORD_TX_PARITY_EN
      bitv[11] = ^w;
`endif
      bitv[NB-1] = 1'b1;
      for (int j = 1; j <= f; j++) begin
         @(negedge clk);
         if (rej > 0 && j == rej) begin
            load4 = 1'b1;
            data4 = 10'h3FF;
         end else if (rej > 0 && j == rej + 1) begin
            load4 = 1'b0;
         end
         check("ser",   j, sel ? ser1   : ser4,   bitv[(j-1)/div]);
         check("done",  j, sel ? done1  : done4,  j == f);
         check("ready", j, sel ? ready1 : ready4, 1'b0);
         check("busy",  j, sel ? busy1  : busy4,  1'b1);
      end
      @(negedge clk);
      check_idle(sel, f + 1);
   endtask

   initial begin
      #20;
      check_idle(0, 0);
      check_idle(1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_idle(0, 0);
         check_idle(1, 0);
      end

      // Single frame, pattern A
      start(0, WA, 1'b0);
      run_frame(0, WA, 0);

      // Held load: back-to-back frames, data changed after second acceptance
      start(0, WB, 1'b1);
      run_frame(0, WB, 0);
      @(posedge clk);
      #1;
      load4 = 1'b0;
      data4 = '0;
      run_frame(0, WB, 0);

      // Load pulse during a frame must be ignored
      start(0, WA, 1'b0);
      run_frame(0, WA, 10);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         check_idle(0, 100 + j);
      end

      // Reset mid-frame
      start(0, WA, 1'b0);
      repeat (20) @(negedge clk);
      check("pre_rst_busy", 20, busy4, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle(0, 20);
      repeat (3) begin
         @(negedge clk);
         check_idle(0, 21);
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_idle(0, 22);
      end
      start(0, WB, 1'b0);
      run_frame(0, WB, 0);

      // DIV = 1 instance
      start(1, WA, 1'b0);
      run_frame(1, WA, 0);
      start(1, WB, 1'b0);
      run_frame(1, WB, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Serial word transmitter for the switch/LED lab designs. Accepts a parallel word (typically captured from `SW`) through a load/ready handshake. Shifts the word out MSB-first on a single line framed by a start bit and a stop bit, at a fixed bit period derived from `CLOCK_50`. It is the transmit end for the team's serial pattern detector/receiver blocks and drives either a GPIO pin or a loop-back into a receiver under test.

## Interface
- `DATA_W`, 10: payload width in bits; legal range 1–32.
- `DIV`, 25: clock cycles per serial bit; legal range ≥ 1 (DIV = 1 must work).

- `CLOCK_50`  in  1  system clock; all state changes on the rising edge.
- `Resetn`  in  1  reset, asynchronous and active-low.
- `data_in`  in  DATA_W  word to transmit; sampled only on an accepted load.
- `load`  in  1  transmit request; accepted in any cycle where `load && ready`.
- `ready`  out  1  high when idle and able to accept a load.
- `ser_out`  out  1  serial line; idles high.
- `busy`  out  1  high from the cycle after acceptance through the last stop-bit cycle.
- `done`  out  1  one-cycle pulse in the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY (only with `PARITY_EN`), STOP.
- IDLE:
  - `ready`=1, `ser_out`=1, `busy`=0.
  - On an accepted load, latch `data_in` into the shift register, clear the bit-period counter, and go to START.
- START: `ser_out`=0 for DIV cycles, then go to DATA with bit index DATA_W-1.
- DATA:
  - `ser_out` = current MSB of the shift register, held for DIV cycles.
  - Then shift left and decrement the index.
  - After bit 0, go to PARITY if enabled, else STOP.
- PARITY: `ser_out` = XOR of all latched payload bits (even parity), held for DIV cycles, then go to STOP.
- STOP: `ser_out`=1 for DIV cycles; `done`=1 in the final cycle; then go to IDLE.
- Loads while busy are ignored. `data_in` changes after acceptance have no effect on the frame in flight.
- The bit-period counter is ceil(log2(DIV)) bits wide (min 1) and counts 0..DIV-1. At DIV-1 it wraps to 0 and the state/bit advances.
- The bit index is ceil(log2(DATA_W)) bits wide (min 1); it never underflows.
- Reset asserted mid-frame: immediately (asynchronously) go to IDLE, `ser_out`=1, `done`=0, shift register cleared. No partial-frame completion.

## Timing
- Reset values: `ready`=1, `ser_out`=1, `busy`=0, `done`=0, state IDLE, counters 0.
- Let acceptance occur at rising edge k.
  - START occupies cycles k+1..k+DIV.
  - Data bit i (MSB = first) occupies the next DIV cycles each.
- Frame length F = (DATA_W+2)·DIV cycles, or (DATA_W+3)·DIV with parity.
- `done` is high in cycle k+F only. `ready` is low in cycles k+1..k+F and high again from cycle k+F+1.
- A load held high continuously is re-accepted at edge k+F+1. Back-to-back frames therefore have exactly one idle-high cycle between the stop bit and the next start bit.
- All outputs are registered; no combinational path from `load`/`data_in` to any output.

## Configuration
- `SERIAL_WORD_TX_PARITY_EN`
  - Defined: the PARITY state is compiled in. One even-parity bit is sent between the last data bit and the stop bit, and F grows by DIV.
  - Undefined: no PARITY state or logic; the frame is start + DATA_W data bits + stop.

## Test plan
- Reset: hold `Resetn`=0 for 20 ns, release → `ser_out`=1, `ready`=1, `busy`=0, `done`=0 until the first load.
- DATA_W=10, DIV=4, load 10'b1010101010 at edge k:
  - `ser_out` = 0,1,0,1,0,1,0,1,0,1,0,1, each level held 4 cycles.
  - `done` only in cycle k+48; `ready` back high at k+49.
- Same configuration, `load` held high with `data_in`=10'b1101010101 → second frame starts at k+50 with start bit 0, then 1,1,0,1,0,1,0,1,0,1, stop 1.
- Busy-load rejection: pulse `load` with 10'h3FF at k+10 during a frame → current frame is unchanged, no extra frame follows.
- Reset mid-frame: drop `Resetn` in cycle k+20 → `ser_out`=1 and `ready`=1 without waiting for a clock edge, `done` never pulses. A new load after release transmits correctly.
- With `SERIAL_WORD_TX_PARITY_EN`, DIV=4:
  - 10'b1010101010 → parity bit 1 in cycles k+45..k+48, `done` at k+52.
  - 10'b1101010101 → parity bit 0.
- DIV=1 variant: 10'b1010101010 → 12 one-cycle bits, `done` at k+12.
